soml_xiq_sched: RTL and testbench

Sequencing controller for the xIxQ_cal datapath in the SOML decoder. One frame request runs xIxQ_cal once per candidate index, 0..NUM_CAND-1. For each run it captures the four 16-bit results (xI1, xI2, xQ1, xQ2) and presents them downstream on a valid/ready handshake. It also guards each run with a timeout and supports a synchronous abort.

---
 rtl/soml_xiq_sched.sv | 153 +++++++++++++++
 tb/tb_soml_xiq_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soml_xiq_sched.sv
`timescale 1ns/1ps
// soml_xiq_sched: runs xIxQ_cal once per candidate of a frame, captures the four
// results per run and hands them downstream on valid/ready, with hang timeout and abort.
module soml_xiq_sched #(
  parameter int NUM_CAND    = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int TMO_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             abort,
  output logic             cal_start,
  output logic [IDX_W-1:0] cal_cand_idx,
  input  logic             cal_done,
  input  logic [15:0]      cal_xI1,
  input  logic [15:0]      cal_xI2,
  input  logic [15:0]      cal_xQ1,
  input  logic [15:0]      cal_xQ2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_cand_idx,
  output logic [15:0]      out_xI1,
  output logic [15:0]      out_xI2,
  output logic [15:0]      out_xQ1,
  output logic [15:0]      out_xQ2,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_d;
  logic [TMO_W-1:0] timer;
  logic [TMO_W-1:0] timer_d;

  logic accept;
  logic capture;
  logic tmo_hit;
  logic handshake;

  logic cal_start_d;
  logic out_valid_d;
  logic frame_busy_d;
  logic frame_done_d;
  logic timeout_err_d;

  // Event qualifiers; abort masks every event it has priority over.
  always_comb begin
    accept    = (state == S_IDLE) && frame_start && !abort;
    capture   = (state == S_WAIT) && cal_done && !abort;
    tmo_hit   = (state == S_WAIT) && !cal_done && !abort && (timer == TMO_LAST);
    handshake = (state == S_HOLD) && out_valid && out_ready && !abort;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_next = state;
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_next = S_ISSUE;
        S_ISSUE: state_next = S_WAIT;
        S_WAIT: begin
          if (capture)      state_next = S_HOLD;
          else if (tmo_hit) state_next = S_IDLE;
        end
        S_HOLD: begin
          if (handshake) state_next = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Registered outputs are loaded from the state being entered, so each one
  // lines up with the state it belongs to without an extra cycle of delay.
  always_comb begin
    cal_start_d   = (state_next == S_ISSUE);
    out_valid_d   = (state_next == S_HOLD);
    frame_busy_d  = (state_next != S_IDLE);
    frame_done_d  = (state_next == S_DONE);

    timeout_err_d = timeout_err;
    if (accept)       timeout_err_d = 1'b0;
    else if (tmo_hit) timeout_err_d = 1'b1;

    idx_d = idx;
    if (accept)                             idx_d = '0;
    else if (handshake && idx != LAST_IDX)  idx_d = idx + 1'b1;

    timer_d = timer;
    if (state == S_ISSUE)     timer_d = '0;
    else if (state == S_WAIT) timer_d = timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cal_start    <= 1'b0;
      out_valid    <= 1'b0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      idx          <= '0;
      timer        <= '0;
      out_cand_idx <= '0;
      out_xI1      <= '0;
      out_xI2      <= '0;
      out_xQ1      <= '0;
      out_xQ2      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cal_start   <= cal_start_d;
      out_valid   <= out_valid_d;
      frame_busy  <= frame_busy_d;
      frame_done  <= frame_done_d;
      timeout_err <= timeout_err_d;
      idx         <= idx_d;
      timer       <= timer_d;
      if (capture) begin
        out_cand_idx <= idx;
        out_xI1      <= cal_xI1;
        out_xI2      <= cal_xI2;
        out_xQ1      <= cal_xQ1;
        out_xQ2      <= cal_xQ2;
      end
    end
  end

  assign cal_cand_idx = idx;

endmodule

// File: tb/tb_soml_xiq_sched.sv
`timescale 1ns/1ps
// Self-checking bench for soml_xiq_sched: directed scenarios plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_soml_xiq_sched;

  localparam int NUM_CAND    = 4;
  localparam int IDX_W       = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int TMO_W       = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_start = 1'b0;
  logic             abort = 1'b0;
  logic             cal_start;
  logic [IDX_W-1:0] cal_cand_idx;
  logic             cal_done = 1'b0;
  logic [15:0]      cal_xI1 = '0, cal_xI2 = '0, cal_xQ1 = '0, cal_xQ2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_cand_idx;
  logic [15:0]      out_xI1, out_xI2, out_xQ1, out_xQ2;
  logic             frame_busy, frame_done, timeout_err;

  always #5 clk = ~clk;

  soml_xiq_sched #(
    .NUM_CAND(NUM_CAND), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .cal_start(cal_start), .cal_cand_idx(cal_cand_idx), .cal_done(cal_done),
    .cal_xI1(cal_xI1), .cal_xI2(cal_xI2), .cal_xQ1(cal_xQ1), .cal_xQ2(cal_xQ2),
    .out_valid(out_valid), .out_ready(out_ready), .out_cand_idx(out_cand_idx),
    .out_xI1(out_xI1), .out_xI2(out_xI2), .out_xQ1(out_xQ1), .out_xQ2(out_xQ2),
    .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: which step of the candidate loop the frame is on,
  // how long the current run has waited, and what the last captured result was.
  bit          m_busy, m_start, m_await, m_hold, m_done, m_tmo;
  int          m_idx, m_wait, m_oidx;
  logic [15:0] m_x [4];

  function automatic void model_reset();
    m_busy = 0; m_start = 0; m_await = 0; m_hold = 0; m_done = 0; m_tmo = 0;
    m_idx = 0; m_wait = 0; m_oidx = 0;
    m_x = '{16'h0, 16'h0, 16'h0, 16'h0};
  endfunction

  function automatic void model_step();
    if (!m_busy) begin
      if (frame_start && !abort) begin
        m_busy = 1; m_tmo = 0; m_idx = 0; m_start = 1;
      end
    end else if (abort) begin
      m_busy = 0; m_start = 0; m_await = 0; m_hold = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_start) begin
      m_start = 0; m_await = 1; m_wait = 0;
    end else if (m_await) begin
      if (cal_done) begin
        m_await = 0; m_hold = 1; m_oidx = m_idx;
        m_x = '{cal_xI1, cal_xI2, cal_xQ1, cal_xQ2};
      end else if (m_wait == TIMEOUT_CYC - 1) begin
        m_await = 0; m_busy = 0; m_tmo = 1;
      end else begin
        m_wait++;
      end
    end else if (m_hold && out_ready) begin
      m_hold = 0;
      if (m_idx == NUM_CAND - 1) m_done = 1;
      else begin m_idx++; m_start = 1; end
    end
  endfunction

  task automatic compare_all();
    check("cal_start", 32'(cal_start), 32'(m_start));
    if (m_busy) check("cal_cand_idx", 32'(cal_cand_idx), 32'(m_idx));
    check("out_valid", 32'(out_valid), 32'(m_hold));
    check("out_cand_idx", 32'(out_cand_idx), 32'(m_oidx));
    check("out_xI1", 32'(out_xI1), 32'(m_x[0]));
    check("out_xI2", 32'(out_xI2), 32'(m_x[1]));
    check("out_xQ1", 32'(out_xQ1), 32'(m_x[2]));
    check("out_xQ2", 32'(out_xQ2), 32'(m_x[3]));
    check("frame_busy", 32'(frame_busy), 32'(m_busy));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("timeout_err", 32'(timeout_err), 32'(m_tmo));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cal_start"}, 32'(cal_start), 0);
    check({tag, " cal_cand_idx"}, 32'(cal_cand_idx), 0);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_cand_idx"}, 32'(out_cand_idx), 0);
    check({tag, " out_x"}, {out_xI1, out_xI2} | {out_xQ1, out_xQ2}, 0);
    check({tag, " frame_busy"}, 32'(frame_busy), 0);
    check({tag, " frame_done"}, 32'(frame_done), 0);
    check({tag, " timeout_err"}, 32'(timeout_err), 0);
  endtask

  // xIxQ_cal stand-in: answers each cal_start after resp_delay cycles unless suppressed.
  bit   resp_armed = 0;
  int   resp_cnt = 0, resp_idx = 0, resp_delay = 3;
  bit   resp_rand = 0;
  int   suppress_idx = -1;
  bit   stray_done = 0;
  int   n_starts = 0, n_done = 0;
  int   start_idx_q[$];
  int   beat_q[$];

  task automatic tick();
    cal_done = 1'b0;
    if (stray_done) begin
      cal_done = 1'b1;
      cal_xI1 = 16'($urandom); cal_xI2 = 16'($urandom);
      cal_xQ1 = 16'($urandom); cal_xQ2 = 16'($urandom);
    end
    if (resp_armed) begin
      if (resp_cnt == 0) begin
        cal_done = 1'b1;
        cal_xI1 = 16'(16'h0010 + resp_idx);
        cal_xI2 = 16'(16'h0020 + resp_idx);
        cal_xQ1 = 16'($urandom); cal_xQ2 = 16'($urandom);
        resp_armed = 0;
      end else begin
        resp_cnt--;
      end
    end
    if (out_valid && out_ready) beat_q.push_back(int'(out_xI1));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    frame_start = 1'b0;
    abort = 1'b0;
    stray_done = 0;
    if (cal_start) begin
      n_starts++;
      start_idx_q.push_back(int'(cal_cand_idx));
      if (int'(cal_cand_idx) != suppress_idx) begin
        resp_armed = 1;
        resp_idx = int'(cal_cand_idx);
        resp_cnt = (resp_rand ? int'($urandom_range(1, 6)) : resp_delay) - 1;
      end
    end
    if (frame_done) n_done++;
  endtask

  task automatic run_until_idx_start(input int want, input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (cal_start && int'(cal_cand_idx) == want) seen = 1;
    end
    check({tag, " start seen"}, 32'(seen), 1);
  endtask

  task automatic run_until_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (frame_done) seen = 1;
    end
    check({tag, " done seen"}, 32'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int starts0, done0, cnt;
    bit seen;
    model_reset();

    // Reset state, asynchronously and across clock edges.
    #2;  check_all_zero("reset_async");
    #14; check_all_zero("reset_held");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Nominal frame.
    out_ready = 1'b1; resp_delay = 3;
    start_idx_q.delete(); beat_q.delete();
    starts0 = n_starts; done0 = n_done;
    frame_start = 1'b1;
    tick();
    check("nom start latency", 32'(cal_start), 1);
    run_until_done("nom");
    check("nom busy in DONE", 32'(frame_busy), 1);
    tick();
    check("nom busy after DONE", 32'(frame_busy), 0);
    check("nom start count", 32'(n_starts - starts0), 4);
    check("nom done count", 32'(n_done - done0), 1);
    for (int i = 0; i < start_idx_q.size() && i < 4; i++)
      check("nom start idx", 32'(start_idx_q[i]), 32'(i));
    check("nom beat count", 32'(beat_q.size()), 4);
    for (int i = 0; i < beat_q.size() && i < 4; i++)
      check("nom beat xI1", 32'(beat_q[i]), 32'(16'h0010 + i));
    stray_done = 1;
    tick();
    check("stray idle out_valid", 32'(out_valid), 0);
    check("stray idle out_xI1", 32'(out_xI1), 32'h0013);
    check("stray idle cal_start", 32'(cal_start), 0);

    // Backpressure on candidate 1, with ignored frame_start and cal_done in HOLD.
    resp_delay = 2; starts0 = n_starts;
    frame_start = 1'b1;
    run_until_idx_start(1, "bp");
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (out_valid) seen = 1; end
    check("bp valid seen", 32'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) stray_done = 1;
      if (i == 6) frame_start = 1'b1;
      tick();
      check("bp hold valid", 32'(out_valid), 1);
      check("bp hold xI1", 32'(out_xI1), 32'h0011);
      check("bp hold idx", 32'(out_cand_idx), 1);
      check("bp no start", 32'(cal_start), 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp released valid", 32'(out_valid), 0);
    check("bp next start", 32'(cal_start), 1);
    check("bp next idx", 32'(cal_cand_idx), 2);
    tick();
    frame_start = 1'b1;
    run_until_done("bp");
    tick();
    check("bp start count", 32'(n_starts - starts0), 4);

    // Timeout on candidate 2, then a new frame clears the flag.
    suppress_idx = 2; done0 = n_done;
    frame_start = 1'b1;
    run_until_idx_start(2, "tmo");
    cnt = 0;
    for (int i = 0; i < 200 && !timeout_err; i++) begin tick(); cnt++; end
    check("tmo cycles in WAIT", 32'(cnt - 1), 64);
    check("tmo busy", 32'(frame_busy), 0);
    check("tmo no done", 32'(n_done - done0), 0);
    tick();
    check("tmo sticky", 32'(timeout_err), 1);

    // Abort in the same cycle as cal_done on candidate 1.
    suppress_idx = 1; done0 = n_done;
    frame_start = 1'b1;
    tick();
    check("tmo cleared", 32'(timeout_err), 0);
    run_until_idx_start(1, "abort");
    tick(); tick();
    stray_done = 1; abort = 1'b1;
    tick();
    check("abort out_valid", 32'(out_valid), 0);
    check("abort idle", 32'(frame_busy), 0);
    check("abort out_idx", 32'(out_cand_idx), 0);
    check("abort out_xI1", 32'(out_xI1), 32'h0010);
    tick();
    check("abort no done", 32'(n_done - done0), 0);
    check("abort no start", 32'(cal_start), 0);
    suppress_idx = -1;

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    frame_start = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin tick(); if (out_valid) seen = 1; end
    check("arst hold seen", 32'(seen), 1);
    #2; rst = 1'b0;
    #1; check_all_zero("arst");
    model_reset(); resp_armed = 0;
    #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Random traffic.
    resp_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      out_ready   = ($urandom_range(0, 99) < 70);
      frame_start = ($urandom_range(0, 99) < 25);
      abort       = ($urandom_range(0, 99) < 2);
      stray_done  = ($urandom_range(0, 99) < 4);
      if (frame_start && !frame_busy)
        suppress_idx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
